// File: rtl/id_token_scanner_if.sv
// Character-stream bus for id_token_scanner: char source side is master,
// scanner side is slave.
interface id_token_scanner_if #(
  parameter int LEN_W = 6,
  parameter int CNT_W = 16
);
  logic             char_valid;
  logic [7:0]       char;
  logic             allow_us;
  logic             clr_cnt;
  logic             out;
  logic             tok_done;
  logic [LEN_W-1:0] tok_len;
  logic             len_ovf;
  logic [CNT_W-1:0] tok_count;

  modport master (
    output char_valid, char, allow_us, clr_cnt,
    input  out, tok_done, tok_len, len_ovf, tok_count
  );

  modport slave (
    input  char_valid, char, allow_us, clr_cnt,
    output out, tok_done, tok_len, len_ovf, tok_count
  );
endinterface

// File: rtl/id_token_scanner.sv
// Streaming identifier recognizer: letters{>=MIN_ALPHA} digits{>=MIN_DIGIT},
// with token length tracking, overflow rejection and a match counter.
module id_token_scanner #(
  parameter int MIN_ALPHA = 1,
  parameter int MIN_DIGIT = 1,
  parameter int LEN_W     = 6,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               reset,
  id_token_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALPHA = 2'd1,
    S_DIGIT = 2'd2,
    S_BAD   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    C_OTHER  = 2'd0,
    C_LETTER = 2'd1,
    C_DIGIT  = 2'd2
  } cls_t;

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] MIN_A   = LEN_W'(MIN_ALPHA);
  localparam logic [LEN_W-1:0] MIN_D   = LEN_W'(MIN_DIGIT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic cls_t classify(input logic [7:0] c, input logic us);
    cls_t k;
    if (((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) ||
        (us && (c == 8'h5F))) begin
      k = C_LETTER;
    end else if ((c >= 8'h30) && (c <= 8'h39)) begin
      k = C_DIGIT;
    end else begin
      k = C_OTHER;
    end
    return k;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    logic [LEN_W-1:0] r;
    if (v == LEN_MAX) begin
      r = LEN_MAX;
    end else begin
      r = v + LEN_ONE;
    end
    return r;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [LEN_W-1:0] alpha_r, alpha_nxt_s;
  logic [LEN_W-1:0] digit_r, digit_nxt_s;
  logic [LEN_W-1:0] len_r, len_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic             out_r, out_nxt_s;
  logic             done_r, done_s;
  logic [CNT_W-1:0] cnt_r;
  cls_t             cls_s;

  assign cls_s = classify(bus.char, bus.allow_us);

  // Next-state, class counters, token length and overflow for one accepted char.
  always_comb begin
    state_nxt_s = state_r;
    alpha_nxt_s = alpha_r;
    digit_nxt_s = digit_r;
    len_nxt_s   = len_r;
    ovf_nxt_s   = ovf_r;
    done_s      = 1'b0;
    if (bus.char_valid) begin
      if (cls_s == C_OTHER) begin
        state_nxt_s = S_IDLE;
        alpha_nxt_s = {LEN_W{1'b0}};
        digit_nxt_s = {LEN_W{1'b0}};
        len_nxt_s   = {LEN_W{1'b0}};
        ovf_nxt_s   = 1'b0;
        done_s      = (state_r == S_DIGIT) && out_r;
      end else if ((cls_s == C_LETTER) && ((state_r == S_IDLE) || (state_r == S_DIGIT))) begin
        // A letter after digits closes the current token and opens a fresh one.
        done_s      = (state_r == S_DIGIT) && out_r;
        state_nxt_s = S_ALPHA;
        alpha_nxt_s = LEN_ONE;
        digit_nxt_s = {LEN_W{1'b0}};
        len_nxt_s   = LEN_ONE;
        ovf_nxt_s   = 1'b0;
      end else begin
        len_nxt_s = sat_inc(len_r);
        case (state_r)
          S_IDLE: begin
            state_nxt_s = S_BAD;
          end
          S_ALPHA: begin
            if (cls_s == C_LETTER) begin
              alpha_nxt_s = sat_inc(alpha_r);
            end else begin
              digit_nxt_s = LEN_ONE;
              state_nxt_s = (alpha_r >= MIN_A) ? S_DIGIT : S_BAD;
            end
          end
          S_DIGIT: begin
            digit_nxt_s = sat_inc(digit_r);
          end
          default: begin
            state_nxt_s = S_BAD;
          end
        endcase
        // Hitting the length ceiling poisons the token until the next delimiter.
        if (len_nxt_s == LEN_MAX) begin
          ovf_nxt_s   = 1'b1;
          state_nxt_s = S_BAD;
        end else begin
          ovf_nxt_s   = ovf_r;
        end
      end
    end else begin
      done_s = 1'b0;
    end
  end

  // Match flag evaluated on the post-transition values so out lags the char by one cycle.
  always_comb begin
    out_nxt_s = (state_nxt_s == S_DIGIT) && (digit_nxt_s >= MIN_D) && !ovf_nxt_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      alpha_r <= {LEN_W{1'b0}};
      digit_r <= {LEN_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      ovf_r   <= 1'b0;
      out_r   <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      alpha_r <= alpha_nxt_s;
      digit_r <= digit_nxt_s;
      len_r   <= len_nxt_s;
      ovf_r   <= ovf_nxt_s;
      out_r   <= out_nxt_s;
      done_r  <= done_s;
      if (bus.clr_cnt) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (done_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign bus.out       = out_r;
  assign bus.tok_done  = done_r;
  assign bus.tok_len   = len_r;
  assign bus.len_ovf   = ovf_r;
  assign bus.tok_count = cnt_r;

endmodule

// File: tb/tb_id_token_scanner.sv
// Bench for id_token_scanner: three parameterizations driven in lockstep,
// checked against a token-string reference model plus hand-derived vectors.
module tb_id_token_scanner;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_token_scanner_if #(.LEN_W(6), .CNT_W(16)) b0 ();
  id_token_scanner_if #(.LEN_W(6), .CNT_W(16)) b1 ();
  id_token_scanner_if #(.LEN_W(3), .CNT_W(16)) b2 ();

  id_token_scanner #(.MIN_ALPHA(1), .MIN_DIGIT(1), .LEN_W(6), .CNT_W(16))
    dut0 (.clk(clk), .reset(reset), .bus(b0));
  id_token_scanner #(.MIN_ALPHA(2), .MIN_DIGIT(2), .LEN_W(6), .CNT_W(16))
    dut1 (.clk(clk), .reset(reset), .bus(b1));
  id_token_scanner #(.MIN_ALPHA(1), .MIN_DIGIT(1), .LEN_W(3), .CNT_W(16))
    dut2 (.clk(clk), .reset(reset), .bus(b2));

  localparam byte KL = 8'h4C;
  localparam byte KD = 8'h44;
  localparam byte KO = 8'h4F;

  int tests = 0;
  int fails = 0;
  int stepn = 0;

  // Reference model: the current token is held as a string of class letters.
  string       tk   [3];
  bit          movf [3];
  bit          mout [3];
  bit          mdone[3];
  int unsigned mcnt [3];
  int          ma   [3] = '{1, 2, 1};
  int          md   [3] = '{1, 2, 1};
  int          mx   [3] = '{63, 63, 7};

  typedef struct {
    byte c;
    bit  v;
    bit  us;
    bit  clr;
    bit  e_out;
    bit  e_done;
    int  e_len;
    int  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic byte cls_of(input byte c, input bit us);
    byte k;
    if ((c >= "A" && c <= "Z") || (c >= "a" && c <= "z") || (us && c == "_")) k = KL;
    else if (c >= "0" && c <= "9") k = KD;
    else k = KO;
    return k;
  endfunction

  // True when s is exactly mina+ letters followed by mind+ digits.
  function automatic bit form_ok(input string s, input int mina, input int mind);
    int i = 0;
    int na = 0;
    int nd = 0;
    while (i < s.len() && s[i] == KL) begin i++; na++; end
    while (i < s.len() && s[i] == KD) begin i++; nd++; end
    return (i == s.len()) && (na >= mina) && (nd >= mind);
  endfunction

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      tk[i] = ""; movf[i] = 1'b0; mout[i] = 1'b0; mdone[i] = 1'b0; mcnt[i] = 0;
    end
  endtask

  task automatic mstep(input int i, input byte c, input bit v, input bit us, input bit clr);
    byte k;
    k = cls_of(c, us);
    mdone[i] = 1'b0;
    if (v) begin
      if (k == KO) begin
        mdone[i] = mout[i];
        tk[i] = "";
        movf[i] = 1'b0;
      end else if (k == KL && !movf[i] && tk[i].len() > 0 && form_ok(tk[i], ma[i], 1)) begin
        mdone[i] = mout[i];
        tk[i] = "L";
      end else if (!movf[i]) begin
        tk[i] = $sformatf("%s%c", tk[i], k);
        if (tk[i].len() == mx[i]) movf[i] = 1'b1;
      end
      mout[i] = !movf[i] && form_ok(tk[i], ma[i], md[i]);
    end
    if (clr) mcnt[i] = 0;
    else if (mdone[i]) mcnt[i] = (mcnt[i] + 1) & 32'h0000FFFF;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @step %0d: got %0d expected %0d", nm, stepn, act, exp);
    end
  endtask

  task automatic cmp_dut(input int i, input logic o, input logic d, input logic [31:0] l,
                         input logic ov, input logic [31:0] cn);
    chk($sformatf("d%0d out", i), {31'd0, o}, {31'd0, mout[i]});
    chk($sformatf("d%0d tok_done", i), {31'd0, d}, {31'd0, mdone[i]});
    chk($sformatf("d%0d tok_len", i), l, tk[i].len());
    chk($sformatf("d%0d len_ovf", i), {31'd0, ov}, {31'd0, movf[i]});
    chk($sformatf("d%0d tok_count", i), cn, mcnt[i]);
  endtask

  task automatic cmp_all();
    cmp_dut(0, b0.out, b0.tok_done, 32'(b0.tok_len), b0.len_ovf, 32'(b0.tok_count));
    cmp_dut(1, b1.out, b1.tok_done, 32'(b1.tok_len), b1.len_ovf, 32'(b1.tok_count));
    cmp_dut(2, b2.out, b2.tok_done, 32'(b2.tok_len), b2.len_ovf, 32'(b2.tok_count));
  endtask

  task automatic drive(input byte c, input bit v, input bit us, input bit clr);
    b0.char = c; b0.char_valid = v; b0.allow_us = us; b0.clr_cnt = clr;
    b1.char = c; b1.char_valid = v; b1.allow_us = us; b1.clr_cnt = clr;
    b2.char = c; b2.char_valid = v; b2.allow_us = us; b2.clr_cnt = clr;
  endtask

  task automatic step(input byte c, input bit v, input bit us, input bit clr);
    drive(c, v, us, clr);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) mstep(i, c, v, us, clr);
    cmp_all();
    stepn++;
  endtask

  task automatic add(input byte c, input bit v, input bit us, input bit clr,
                     input bit eo, input bit ed, input int el, input int ec);
    vec_t e;
    e.c = c; e.v = v; e.us = us; e.clr = clr;
    e.e_out = eo; e.e_done = ed; e.e_len = el; e.e_cnt = ec;
    tbl.push_back(e);
  endtask

  byte alph[8] = '{8'h61, 8'h5A, 8'h5F, 8'h30, 8'h39, 8'h20, 8'h2C, 8'h7B};

  initial begin
    reset = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    @(negedge clk);
    reset = 1'b0;

    // Expected values for the MIN=1/LEN_W=6 instance, derived by hand.
    add("a", 1, 0, 0, 0, 0, 1, 0); add("b", 1, 0, 0, 0, 0, 2, 0);
    add("1", 1, 0, 0, 1, 0, 3, 0); add("2", 1, 0, 0, 1, 0, 4, 0);
    add(" ", 1, 0, 0, 0, 1, 0, 1);
    add("1", 1, 0, 0, 0, 0, 1, 1); add("a", 1, 0, 0, 0, 0, 2, 1);
    add("2", 1, 0, 0, 0, 0, 3, 1); add(" ", 1, 0, 0, 0, 0, 0, 1);
    add("x", 1, 0, 0, 0, 0, 1, 1); add("9", 1, 0, 0, 1, 0, 2, 1);
    add("y", 1, 0, 0, 0, 1, 1, 2); add("7", 1, 0, 0, 1, 0, 2, 2);
    add(",", 1, 0, 0, 0, 1, 0, 3);
    add("_", 1, 0, 0, 0, 0, 0, 3); add("9", 1, 0, 0, 0, 0, 1, 3);
    add(" ", 1, 0, 0, 0, 0, 0, 3);
    add("_", 1, 1, 0, 0, 0, 1, 3); add("a", 1, 1, 0, 0, 0, 2, 3);
    add("1", 1, 1, 0, 1, 0, 3, 3); add(" ", 1, 1, 0, 0, 1, 0, 4);
    add("a", 1, 0, 0, 0, 0, 1, 4); add("z", 0, 0, 0, 0, 0, 1, 4);
    add("1", 1, 0, 0, 1, 0, 2, 4); add(" ", 0, 0, 0, 1, 0, 2, 4);
    add("5", 0, 0, 0, 1, 0, 2, 4); add(" ", 1, 0, 1, 0, 1, 0, 0);
    add("q", 1, 0, 0, 0, 0, 1, 0); add("3", 1, 0, 0, 1, 0, 2, 0);
    add(" ", 1, 0, 0, 0, 1, 0, 1); add("k", 1, 0, 1, 0, 0, 1, 0);
    add(" ", 1, 0, 0, 0, 0, 0, 0);

    foreach (tbl[n]) begin
      step(tbl[n].c, tbl[n].v, tbl[n].us, tbl[n].clr);
      chk($sformatf("vec%0d out", n), {31'd0, b0.out}, {31'd0, tbl[n].e_out});
      chk($sformatf("vec%0d tok_done", n), {31'd0, b0.tok_done}, {31'd0, tbl[n].e_done});
      chk($sformatf("vec%0d tok_len", n), 32'(b0.tok_len), tbl[n].e_len);
      chk($sformatf("vec%0d tok_count", n), 32'(b0.tok_count), tbl[n].e_cnt);
    end

    // MIN_ALPHA=2 / MIN_DIGIT=2 instance.
    step("a", 1, 0, 0); step("1", 1, 0, 0); step("2", 1, 0, 0);
    chk("m2 a12 out", {31'd0, b1.out}, 32'd0);
    step(" ", 1, 0, 0);
    chk("m2 a12 done", {31'd0, b1.tok_done}, 32'd0);
    step("a", 1, 0, 0); step("b", 1, 0, 0); step("1", 1, 0, 0);
    chk("m2 ab1 out", {31'd0, b1.out}, 32'd0);
    step("2", 1, 0, 0);
    chk("m2 ab12 out", {31'd0, b1.out}, 32'd1);
    step(" ", 1, 0, 0);
    chk("m2 ab12 done", {31'd0, b1.tok_done}, 32'd1);

    // LEN_W=3 instance: overflow at the 7th char.
    step("a", 1, 0, 0); step("b", 1, 0, 0); step("c", 1, 0, 0);
    step("d", 1, 0, 0); step("e", 1, 0, 0); step("f", 1, 0, 0);
    chk("ovf pre len_ovf", {31'd0, b2.len_ovf}, 32'd0);
    step("g", 1, 0, 0);
    chk("ovf g len_ovf", {31'd0, b2.len_ovf}, 32'd1);
    chk("ovf g tok_len", 32'(b2.tok_len), 32'd7);
    step("1", 1, 0, 0);
    chk("ovf 1 tok_len", 32'(b2.tok_len), 32'd7);
    chk("ovf 1 out", {31'd0, b2.out}, 32'd0);
    step(" ", 1, 0, 0);
    chk("ovf sp done", {31'd0, b2.tok_done}, 32'd0);
    chk("ovf sp len_ovf", {31'd0, b2.len_ovf}, 32'd0);

    // Async reset between edges in the middle of a matching token.
    step("a", 1, 0, 0); step("b", 1, 0, 0); step("1", 1, 0, 0);
    chk("pre-rst out", {31'd0, b0.out}, 32'd1);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    mreset();
    chk("rst out", {31'd0, b0.out}, 32'd0);
    chk("rst tok_len", 32'(b0.tok_len), 32'd0);
    chk("rst tok_count", 32'(b0.tok_count), 32'd0);
    cmp_all();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic; bursts with rare delimiters push tokens into overflow.
    for (int r = 0; r < 3000; r++) begin
      int idx;
      bit long_tok;
      long_tok = ((r / 200) % 3) == 2;
      if (long_tok) idx = ($urandom_range(0, 39) == 0) ? 5 : $urandom_range(0, 4);
      else idx = $urandom_range(0, 7);
      step(alph[idx], $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
